// File: rtl/cache_pkg.sv
// Constants shared by the cache and its refill engine: AXI burst/response codes,
// line geometry helpers and the refill FSM state encoding.
package cache_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } refill_state_t;

  function automatic int line_beats(input int line_size_bits, input int data_width);
    return (1 << line_size_bits) / (data_width / 8);
  endfunction

  // One spare bit so the counter can hold BEATS itself without wrapping.
  function automatic int beat_cnt_width(input int beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/cache_refill_master.sv
// AXI4 read-burst master that refills one cache line per miss; fill beats appear 1 cycle after each R handshake.
// Fills are never back-pressured (rready stays high for the whole burst); only arready can stall the engine.
module cache_refill_master
  import cache_pkg::*;
#(
  parameter int C_ADDR_WIDTH     = 16,
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_LINE_SIZE_BITS = 7
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        miss,
  input  logic [C_ADDR_WIDTH-1:0]     cpu_addr,
  output logic [C_ADDR_WIDTH-1:0]     mem_addr,
  output logic [C_DATA_WIDTH-1:0]     mem_data_in,
  output logic [C_DATA_WIDTH/8-1:0]   mem_wstb,
  output logic                        mem_data_valid,
  output logic                        mem_last,
  output logic [C_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [C_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic                        refill_busy,
  output logic                        refill_err
);

  localparam int AW    = C_ADDR_WIDTH;
  localparam int DW    = C_DATA_WIDTH;
  localparam int LB    = C_LINE_SIZE_BITS;
  localparam int BYTES = DW / 8;
  localparam int BEATS = line_beats(LB, DW);
  localparam int CW    = beat_cnt_width(BEATS);
  localparam int SZ    = $clog2(BYTES);

  if ((DW % 8) != 0 || BEATS < 1 || BEATS > 256 || AW <= LB) begin : g_bad_cfg
    $error("cache_refill_master: unsupported line/bus geometry");
  end

  refill_state_t        state_q, state_d;
  logic [AW-1:0]        araddr_q, araddr_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_data_q, mem_data_d;
  logic [BYTES-1:0]     mem_wstb_q, mem_wstb_d;
  logic                 mem_vld_q, mem_vld_d;
  logic                 mem_last_q, mem_last_d;
  logic                 err_q, err_d;

  logic                 beat_hs;
  logic                 last_by_cnt;
  logic [LB-1:0]        beat_off;

  assign beat_hs     = m_axi_rvalid & rready_q;
  assign last_by_cnt = (cnt_q == CW'(BEATS - 1));
  // Offset is truncated to the line width so a beat address can never carry into the tag/set bits.
  assign beat_off    = LB'(cnt_q) << SZ;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      araddr_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wstb_q <= '0;
      mem_vld_q  <= 1'b0;
      mem_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wstb_q <= mem_wstb_d;
      mem_vld_q  <= mem_vld_d;
      mem_last_q <= mem_last_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_wstb_d = mem_wstb_q;
    mem_vld_d  = 1'b0;
    mem_last_d = 1'b0;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (miss) begin
          araddr_d  = {cpu_addr[AW-1:LB], {LB{1'b0}}};
          arvalid_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_hs) begin
          mem_vld_d  = 1'b1;
          mem_data_d = m_axi_rdata;
          mem_wstb_d = '1;
          mem_addr_d = {araddr_q[AW-1:LB], beat_off};
          cnt_d      = cnt_q + CW'(1);
          // Either the counter or the slave may end the burst; any disagreement is flagged.
          if (last_by_cnt || m_axi_rlast) begin
            mem_last_d = 1'b1;
            rready_d   = 1'b0;
            state_d    = ST_DONE;
          end
          if ((m_axi_rlast != last_by_cnt) || (m_axi_rresp != RESP_OKAY)) begin
            err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Wait for the cache to drop miss so the stale flag cannot start a second refill.
        if (!miss) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr       = mem_addr_q;
  assign mem_data_in    = mem_data_q;
  assign mem_wstb       = mem_wstb_q;
  assign mem_data_valid = mem_vld_q;
  assign mem_last       = mem_last_q;
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arlen    = 8'(BEATS - 1);
  assign m_axi_arsize   = 3'(SZ);
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;
  assign refill_busy    = (state_q != ST_IDLE);
  assign refill_err     = err_q;

endmodule

// File: tb/tb_cache_refill_master.sv
// Directed bench for cache_refill_master with default geometry (32 beats of 4 bytes per line).
module tb_cache_refill_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        miss = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_wstb;
  logic        mem_data_valid, mem_last;
  logic [15:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic        refill_busy, refill_err;

  always #5 clk = ~clk;

  cache_refill_master dut (
    .clk(clk), .reset_n(reset_n), .miss(miss), .cpu_addr(cpu_addr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wstb(mem_wstb),
    .mem_data_valid(mem_data_valid), .mem_last(mem_last),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .refill_busy(refill_busy), .refill_err(refill_err)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] cap_addr [64];
  logic [31:0] cap_data [64];
  logic [3:0]  cap_wstb [64];
  logic        cap_last [64];
  int          ncap;
  int          kk;
  int          tag;
  logic [15:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  bit ar_unstable, early_rready, post_hs_bad, extra_ar, rready_low, timeout;
  bit busy_at_last, busy_after, vld_after;

  function automatic logic [31:0] pat(input int t, input int k);
    return 32'hC0DE0000 | (32'(t) << 8) | 32'(k);
  endfunction

  task automatic drive_r(input int nsend, input int gap_pct, input int err_beat, input int rlast_beat);
    if (kk < nsend && $urandom_range(0, 99) >= gap_pct) begin
      if (!m_axi_rready) rready_low = 1;
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = pat(tag, kk);
      m_axi_rresp  = (kk + 1 == err_beat) ? 2'b10 : 2'b00;
      m_axi_rlast  = (kk + 1 == rlast_beat);
      kk++;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
  endtask

  // Plays both the CPU/cache side and the AXI slave for one refill, recording what the DUT did.
  task automatic do_refill(input logic [15:0] addr, input int ar_wait, input int gap_pct,
                           input int err_beat, input int rlast_beat, input int nsend, input int abort_beat);
    int cyc;
    bit done;
    ncap = 0; kk = 0; done = 0;
    ar_unstable = 0; early_rready = 0; post_hs_bad = 0; extra_ar = 0; rready_low = 0; timeout = 0;
    busy_at_last = 0; busy_after = 1; vld_after = 1;
    for (int i = 0; i < 64; i++) begin
      cap_addr[i] = '0; cap_data[i] = '0; cap_wstb[i] = '0; cap_last[i] = 1'b0;
    end
    @(negedge clk);
    miss = 1'b1; cpu_addr = addr; m_axi_arready = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (m_axi_rready) early_rready = 1;
    end while (!m_axi_arvalid && cyc < 10);
    if (!m_axi_arvalid) begin
      timeout = 1; miss = 1'b0;
      return;
    end
    ar_addr = m_axi_araddr; ar_len = m_axi_arlen; ar_size = m_axi_arsize; ar_burst = m_axi_arburst;
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk);
      if (!m_axi_arvalid || m_axi_araddr !== ar_addr || m_axi_arlen !== ar_len || m_axi_rready) ar_unstable = 1;
    end
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    if (m_axi_arvalid || !m_axi_rready) post_hs_bad = 1;
    drive_r(nsend, gap_pct, err_beat, rlast_beat);
    cyc = 0;
    while (!done && cyc < 600) begin
      @(negedge clk); cyc++;
      if (m_axi_arvalid) extra_ar = 1;
      if (mem_data_valid) begin
        if (ncap < 64) begin
          cap_addr[ncap] = mem_addr; cap_data[ncap] = mem_data_in;
          cap_wstb[ncap] = mem_wstb; cap_last[ncap] = mem_last;
        end
        ncap++;
        if (mem_last) done = 1;
      end
      if (!done && abort_beat != 0 && kk == abort_beat - 1) begin
        drive_r(nsend, 0, err_beat, rlast_beat);
        reset_n = 1'b0;
        return;
      end
      if (!done) drive_r(nsend, gap_pct, err_beat, rlast_beat);
      else begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; miss = 1'b0;
      end
    end
    if (!done) begin
      timeout = 1; miss = 1'b0; m_axi_rvalid = 1'b0;
      return;
    end
    busy_at_last = refill_busy;
    @(negedge clk);
    busy_after = refill_busy;
    vld_after = mem_data_valid;
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    reset_n = 1'b0; miss = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_addr, mem_data_in, mem_wstb, mem_data_valid, mem_last} !== '0)
      begin failures++; $display("FAIL reset_fill got addr=%h data=%h wstb=%h vld=%b last=%b want all zero",
                                 mem_addr, mem_data_in, mem_wstb, mem_data_valid, mem_last); end
    checks++;
    if ({m_axi_araddr, m_axi_arvalid, m_axi_rready, refill_busy, refill_err} !== '0)
      begin failures++; $display("FAIL reset_axi got araddr=%h arvalid=%b rready=%b busy=%b err=%b want all zero",
                                 m_axi_araddr, m_axi_arvalid, m_axi_rready, refill_busy, refill_err); end
    checks++;
    if (m_axi_arlen !== 8'd31 || m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01)
      begin failures++; $display("FAIL ar_const got len=%0d size=%0d burst=%b want 31 2 01",
                                 m_axi_arlen, m_axi_arsize, m_axi_arburst); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (refill_busy !== 1'b0 || m_axi_arvalid !== 1'b0)
      begin failures++; $display("FAIL idle_no_miss got busy=%b arvalid=%b want 0 0", refill_busy, m_axi_arvalid); end
  endtask

  task automatic test_basic;
    tag = 1;
    do_refill(16'h1234, 0, 0, 0, 32, 32, 0);
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL basic_timeout got %b want 0", timeout); end
    checks++;
    if (ar_addr !== 16'h1200 || ar_len !== 8'd31 || ar_burst !== 2'b01 || ar_size !== 3'd2)
      begin failures++; $display("FAIL basic_ar got addr=%h len=%0d burst=%b size=%0d want 1200 31 01 2",
                                 ar_addr, ar_len, ar_burst, ar_size); end
    checks++;
    if (ncap !== 32) begin failures++; $display("FAIL basic_beats got %0d want 32", ncap); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (cap_addr[i] !== 16'h1200 + 16'(i * 4) || cap_data[i] !== pat(1, i) ||
          cap_wstb[i] !== 4'hF || cap_last[i] !== (i == 31))
        begin failures++; $display("FAIL basic_beat%0d got addr=%h data=%h wstb=%h last=%b want %h %h f %b",
                                   i, cap_addr[i], cap_data[i], cap_wstb[i], cap_last[i],
                                   16'h1200 + 16'(i * 4), pat(1, i), (i == 31)); end
    end
    checks++;
    if (refill_err !== 1'b0) begin failures++; $display("FAIL basic_err got %b want 0", refill_err); end
    checks++;
    if (busy_at_last !== 1'b1 || busy_after !== 1'b0 || vld_after !== 1'b0)
      begin failures++; $display("FAIL basic_done got busy_last=%b busy_after=%b vld_after=%b want 1 0 0",
                                 busy_at_last, busy_after, vld_after); end
    checks++;
    if ({early_rready, post_hs_bad, extra_ar, rready_low} !== 4'b0)
      begin failures++; $display("FAIL basic_handshake got early=%b post=%b extra_ar=%b rready_low=%b want 0",
                                 early_rready, post_hs_bad, extra_ar, rready_low); end
  endtask

  task automatic test_ar_stall;
    tag = 2;
    do_refill(16'h5678, 5, 0, 0, 32, 32, 0);
    checks++;
    if (ar_addr !== 16'h5600) begin failures++; $display("FAIL stall_araddr got %h want 5600", ar_addr); end
    checks++;
    if (ar_unstable !== 1'b0 || early_rready !== 1'b0)
      begin failures++; $display("FAIL stall_hold got unstable=%b early_rready=%b want 0 0", ar_unstable, early_rready); end
    checks++;
    if (ncap !== 32 || cap_addr[31] !== 16'h567C || cap_last[31] !== 1'b1 || cap_data[0] !== pat(2, 0))
      begin failures++; $display("FAIL stall_fill got n=%0d last_addr=%h last=%b d0=%h want 32 567c 1 %h",
                                 ncap, cap_addr[31], cap_last[31], cap_data[0], pat(2, 0)); end
  endtask

  task automatic test_gapped;
    tag = 3;
    do_refill(16'hFFC5, 0, 50, 0, 32, 32, 0);
    checks++;
    if (timeout !== 1'b0 || ncap !== 32)
      begin failures++; $display("FAIL gap_count got timeout=%b n=%0d want 0 32", timeout, ncap); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (cap_addr[i] !== 16'hFF80 + 16'(i * 4) || cap_data[i] !== pat(3, i) || cap_last[i] !== (i == 31))
        begin failures++; $display("FAIL gap_beat%0d got addr=%h data=%h last=%b want %h %h %b",
                                   i, cap_addr[i], cap_data[i], cap_last[i],
                                   16'hFF80 + 16'(i * 4), pat(3, i), (i == 31)); end
    end
    checks++;
    if (refill_err !== 1'b0) begin failures++; $display("FAIL gap_err got %b want 0", refill_err); end
  endtask

  task automatic test_rresp_err;
    tag = 4;
    do_refill(16'h2040, 0, 0, 7, 32, 32, 0);
    checks++;
    if (ncap !== 32 || cap_data[6] !== pat(4, 6) || cap_addr[6] !== 16'h2018)
      begin failures++; $display("FAIL slverr_data got n=%0d d6=%h a6=%h want 32 %h 2018",
                                 ncap, cap_data[6], cap_addr[6], pat(4, 6)); end
    checks++;
    if (refill_err !== 1'b1) begin failures++; $display("FAIL slverr_flag got %b want 1", refill_err); end
    tag = 5;
    do_refill(16'h3000, 0, 0, 0, 32, 32, 0);
    checks++;
    if (ncap !== 32 || refill_err !== 1'b1)
      begin failures++; $display("FAIL err_sticky got n=%0d err=%b want 32 1", ncap, refill_err); end
  endtask

  task automatic test_rlast_mismatch;
    pulse_reset();
    checks++;
    if (refill_err !== 1'b0) begin failures++; $display("FAIL err_clear got %b want 0", refill_err); end
    tag = 6;
    do_refill(16'h4444, 0, 0, 0, 16, 16, 0);
    checks++;
    if (ncap !== 16 || cap_last[15] !== 1'b1 || cap_addr[15] !== 16'h443C || cap_last[14] !== 1'b0)
      begin failures++; $display("FAIL early_last got n=%0d last15=%b a15=%h last14=%b want 16 1 443c 0",
                                 ncap, cap_last[15], cap_addr[15], cap_last[14]); end
    checks++;
    if (busy_at_last !== 1'b1 || busy_after !== 1'b0 || refill_err !== 1'b1)
      begin failures++; $display("FAIL early_done got busy_last=%b busy_after=%b err=%b want 1 0 1",
                                 busy_at_last, busy_after, refill_err); end
    pulse_reset();
    tag = 7;
    do_refill(16'h4500, 0, 0, 0, 0, 32, 0);
    checks++;
    if (timeout !== 1'b0 || ncap !== 32 || cap_last[31] !== 1'b1 || refill_err !== 1'b1)
      begin failures++; $display("FAIL no_rlast got timeout=%b n=%0d last31=%b err=%b want 0 32 1 1",
                                 timeout, ncap, cap_last[31], refill_err); end
  endtask

  task automatic test_reset_mid_burst;
    pulse_reset();
    tag = 8;
    do_refill(16'h6100, 0, 0, 0, 32, 32, 10);
    @(negedge clk);
    checks++;
    if (ncap !== 9) begin failures++; $display("FAIL abort_beats got %0d want 9", ncap); end
    checks++;
    if ({mem_addr, mem_data_in, mem_wstb, mem_data_valid, mem_last, m_axi_araddr,
         m_axi_arvalid, m_axi_rready, refill_busy, refill_err} !== '0)
      begin failures++; $display("FAIL abort_outputs got vld=%b last=%b araddr=%h rready=%b busy=%b addr=%h want all zero",
                                 mem_data_valid, mem_last, m_axi_araddr, m_axi_rready, refill_busy, mem_addr); end
    reset_n = 1'b1; miss = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    tag = 9;
    do_refill(16'h0080, 0, 0, 0, 32, 32, 0);
    checks++;
    if (ar_addr !== 16'h0080 || ncap !== 32 || cap_addr[0] !== 16'h0080 || cap_addr[31] !== 16'h00FC)
      begin failures++; $display("FAIL after_abort got araddr=%h n=%0d a0=%h a31=%h want 0080 32 0080 00fc",
                                 ar_addr, ncap, cap_addr[0], cap_addr[31]); end
    checks++;
    if (refill_err !== 1'b0 || cap_data[31] !== pat(9, 31))
      begin failures++; $display("FAIL after_abort_data got err=%b d31=%h want 0 %h", refill_err, cap_data[31], pat(9, 31)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_stall();
    test_gapped();
    test_rresp_err();
    test_rlast_mismatch();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t want completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
